// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32 decode with control unit, sign extender, register file,
//            load-use hazard detection and the ID/EX pipeline register.
//            Optional macro DECODE_BYPASS_EN: same-cycle writeback-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] inc_pc_d,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            reg_write_w,
  input  logic [AW-1:0]   rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            hazard_o,
  output logic            valid_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            alu_src_a_e,
  output logic            alu_src_b_e,
  output logic [1:0]      result_src_e,
  output logic [3:0]      alu_ctrl_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] rs1_e,
  output logic [XLEN-1:0] rs2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] inc_pc_e,
  output logic [AW-1:0]   rd_e,
  output logic [AW-1:0]   rs1_addr_e,
  output logic [AW-1:0]   rs2_addr_e,
  output logic [XLEN-1:0] a0
);

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b0001;
  localparam logic [3:0] c_ALU_AND  = 4'b0010;
  localparam logic [3:0] c_ALU_OR   = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_SLT  = 4'b0101;
  localparam logic [3:0] c_ALU_SLTU = 4'b0110;
  localparam logic [3:0] c_ALU_SLL  = 4'b0111;
  localparam logic [3:0] c_ALU_SRL  = 4'b1000;
  localparam logic [3:0] c_ALU_SRA  = 4'b1001;
  localparam logic [3:0] c_ALU_LUI  = 4'b1010;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [AW-1:0]   w_rs1_addr, w_rs2_addr, w_rd_addr;
  logic            w_reg_write, w_mem_write, w_branch, w_jump;
  logic            w_alu_src_a, w_alu_src_b, w_use_rs1, w_use_rs2;
  logic [1:0]      w_result_src, w_alu_op;
  logic [2:0]      w_imm_src;
  logic [3:0]      w_alu_ctrl;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic [11:0]     w_ctl_dec;

  assign w_opcode   = instr_d[6:0];
  assign w_funct3   = instr_d[14:12];
  assign w_rd_addr  = instr_d[7 +: AW];
  assign w_rs1_addr = instr_d[15 +: AW];
  assign w_rs2_addr = instr_d[20 +: AW];

  // alu_op: 00 add, 01 sub (branch compare), 10 funct decode, 11 pass immediate
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 1'b0;
    w_result_src = 2'b00;
    w_imm_src    = 3'b000;
    w_alu_op     = 2'b00;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    case (w_opcode)
      7'b0000011: begin w_reg_write = 1'b1; w_alu_src_b = 1'b1; w_result_src = 2'b01; w_use_rs1 = 1'b1; end
      7'b0100011: begin w_mem_write = 1'b1; w_alu_src_b = 1'b1; w_imm_src = 3'b001;
                        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      7'b0110011: begin w_reg_write = 1'b1; w_alu_op = 2'b10; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      7'b0010011: begin w_reg_write = 1'b1; w_alu_src_b = 1'b1; w_alu_op = 2'b10; w_use_rs1 = 1'b1; end
      7'b1100011: begin w_branch = 1'b1; w_imm_src = 3'b010; w_alu_op = 2'b01;
                        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      7'b1101111: begin w_jump = 1'b1; w_reg_write = 1'b1; w_result_src = 2'b10; w_imm_src = 3'b011; end
      7'b1100111: begin w_jump = 1'b1; w_reg_write = 1'b1; w_result_src = 2'b10;
                        w_alu_src_b = 1'b1; w_use_rs1 = 1'b1; end
      7'b0110111: begin w_reg_write = 1'b1; w_alu_src_b = 1'b1; w_imm_src = 3'b100; w_alu_op = 2'b11; end
      7'b0010111: begin w_reg_write = 1'b1; w_alu_src_a = 1'b1; w_alu_src_b = 1'b1; w_imm_src = 3'b100; end
      default: ;
    endcase
  end

  // SUB only for R-type: addi with a negative immediate also has bit 30 set
  always_comb begin
    w_alu_ctrl = c_ALU_ADD;
    case (w_alu_op)
      2'b01: w_alu_ctrl = c_ALU_SUB;
      2'b11: w_alu_ctrl = c_ALU_LUI;
      2'b10: begin
        case (w_funct3)
          3'b000:  w_alu_ctrl = (w_opcode[5] && instr_d[30]) ? c_ALU_SUB : c_ALU_ADD;
          3'b001:  w_alu_ctrl = c_ALU_SLL;
          3'b010:  w_alu_ctrl = c_ALU_SLT;
          3'b011:  w_alu_ctrl = c_ALU_SLTU;
          3'b100:  w_alu_ctrl = c_ALU_XOR;
          3'b101:  w_alu_ctrl = instr_d[30] ? c_ALU_SRA : c_ALU_SRL;
          3'b110:  w_alu_ctrl = c_ALU_OR;
          default: w_alu_ctrl = c_ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_imm_src)
      3'b001:  w_imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      3'b010:  w_imm32 = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      3'b011:  w_imm32 = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      3'b100:  w_imm32 = {instr_d[31:12], 12'b0};
      default: w_imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
    endcase
  end

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (reg_write_w && rd_w != '0) begin
      regs_q[rd_w] <= result_w;
    end
  end

  always_comb begin
    w_rs1_val = (w_rs1_addr == '0) ? '0 : regs_q[w_rs1_addr];
    w_rs2_val = (w_rs2_addr == '0) ? '0 : regs_q[w_rs2_addr];
`ifdef DECODE_BYPASS_EN
    if (reg_write_w && rd_w != '0 && rd_w == w_rs1_addr) w_rs1_val = result_w;
    if (reg_write_w && rd_w != '0 && rd_w == w_rs2_addr) w_rs2_val = result_w;
`endif
  end

  assign a0 = regs_q[10];

  logic            valid_e_q, valid_e_d;
  logic [11:0]     ctl_e_q, ctl_e_d;
  logic            load_data;
  logic [2:0]      funct3_e_q;
  logic [AW-1:0]   rd_e_q, rs1_addr_e_q, rs2_addr_e_q;
  logic [XLEN-1:0] rs1_e_q, rs2_e_q, imm_e_q, pc_e_q, inc_pc_e_q;

  assign w_ctl_dec = {w_jump, w_branch, w_reg_write, w_mem_write, w_alu_src_a, w_alu_src_b,
                      w_result_src, w_alu_ctrl};

  assign hazard_o = valid_d && valid_e_q && (ctl_e_q[5:4] == 2'b01) && (rd_e_q != '0) &&
                    ((w_use_rs1 && w_rs1_addr == rd_e_q) || (w_use_rs2 && w_rs2_addr == rd_e_q));

  // Priority: flush > stall > hazard bubble > normal load
  always_comb begin
    valid_e_d = valid_e_q;
    ctl_e_d   = ctl_e_q;
    load_data = 1'b0;
    if (flush_i || (!stall_i && hazard_o)) begin
      valid_e_d = 1'b0;
      ctl_e_d   = '0;
    end else if (!stall_i) begin
      valid_e_d = valid_d;
      ctl_e_d   = valid_d ? w_ctl_dec : '0;
      load_data = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e_q    <= 1'b0;
      ctl_e_q      <= '0;
      funct3_e_q   <= '0;
      rd_e_q       <= '0;
      rs1_addr_e_q <= '0;
      rs2_addr_e_q <= '0;
      rs1_e_q      <= '0;
      rs2_e_q      <= '0;
      imm_e_q      <= '0;
      pc_e_q       <= '0;
      inc_pc_e_q   <= '0;
    end else begin
      valid_e_q <= valid_e_d;
      ctl_e_q   <= ctl_e_d;
      if (load_data) begin
        funct3_e_q   <= w_funct3;
        rd_e_q       <= w_rd_addr;
        rs1_addr_e_q <= w_rs1_addr;
        rs2_addr_e_q <= w_rs2_addr;
        rs1_e_q      <= w_rs1_val;
        rs2_e_q      <= w_rs2_val;
        imm_e_q      <= XLEN'($signed(w_imm32));
        pc_e_q       <= pc_d;
        inc_pc_e_q   <= inc_pc_d;
      end
    end
  end

  assign valid_e      = valid_e_q;
  assign {jump_e, branch_e, reg_write_e, mem_write_e, alu_src_a_e, alu_src_b_e,
          result_src_e, alu_ctrl_e} = ctl_e_q;
  assign funct3_e     = funct3_e_q;
  assign rd_e         = rd_e_q;
  assign rs1_addr_e   = rs1_addr_e_q;
  assign rs2_addr_e   = rs2_addr_e_q;
  assign rs1_e        = rs1_e_q;
  assign rs2_e        = rs2_e_q;
  assign imm_ext_e    = imm_e_q;
  assign pc_e         = pc_e_q;
  assign inc_pc_e     = inc_pc_e_q;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001 SHALL have parameter XLEN, default 32: datapath width of PC, immediate and register data.
- REQ-002 SHALL have parameter NREG, default 32: number of architectural registers (16 selects RV32E); AW = $clog2(NREG).
- REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
- REQ-004 rst_n  in  1  asynchronous active-low reset.
- REQ-005 valid_d  in  1  instr_d/pc_d/inc_pc_d hold a real instruction.
- REQ-006 instr_d  in  32  instruction in decode.
- REQ-007 pc_d, inc_pc_d  in  XLEN  PC and PC+4 of instr_d.
- REQ-008 stall_i  in  1  downstream stall; hold ID/EX register.
- REQ-009 flush_i  in  1  branch/jump flush; bubble into ID/EX.
- REQ-010 reg_write_w  in  1, rd_w  in  AW, result_w  in  XLEN  writeback port.
- REQ-011 hazard_o  out  1  load-use hazard; fetch and decode must hold.
- REQ-012 valid_e  out  1; jump_e, branch_e, reg_write_e, mem_write_e, alu_src_a_e, alu_src_b_e  out  1 each; result_src_e  out  2; alu_ctrl_e  out  4; funct3_e  out  3.
- REQ-013 rs1_e, rs2_e, imm_ext_e, pc_e, inc_pc_e  out  XLEN; rd_e, rs1_addr_e, rs2_addr_e  out  AW.
- REQ-014 a0  out  XLEN  live value of register 10.

Function
- REQ-015 SHALL decode instr_d combinationally via the team's control unit and sign extender (3-bit ImmSrc); register addresses truncated to AW bits.
- REQ-016 SHALL contain NREG x XLEN register file: two async reads, one write on rising clk when reg_write_w and rd_w != 0.
- REQ-017 Register 0 SHALL read 0 always; writes to it ignored.
- REQ-018 hazard_o SHALL be 1 iff valid_d, valid_e, result_src_e == 2'b01, rd_e != 0, and rd_e equals a source address of instr_d actually used by its opcode.
- REQ-019 ID/EX update priority per rising clk: flush_i > stall_i > hazard_o > load.
- REQ-020 flush_i=1: valid_e<=0 and all control outputs <=0, regardless of stall_i.
- REQ-021 stall_i=1 (no flush): all ID/EX outputs hold; hazard_o still computed.
- REQ-022 hazard_o=1 (no flush/stall): bubble inserted (valid_e<=0, controls <=0); data fields don't-care.
- REQ-023 Otherwise: all *_e fields <= decoded values; valid_e <= valid_d; controls forced 0 when valid_d=0.
- REQ-024 Latency: decode to *_e exactly one cycle; hazard costs exactly one bubble.

Reset
- REQ-025 rst_n low SHALL asynchronously clear valid_e, all *_e outputs and every register to 0; a0 reads 0.
- REQ-026 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; first edge after release loads normally.

Configuration
- REQ-027 DECODE_BYPASS_EN defined: a read of rd_w (non-zero) while reg_write_w=1 SHALL return result_w in the same cycle.
- REQ-028 DECODE_BYPASS_EN undefined: such a read SHALL return the pre-write value; no other behaviour differs.

Verification
- REQ-029 Reset: rst_n=0 mid-cycle -> valid_e=0, a0=0 immediately, asynchronously.
- REQ-030 addi x10,x0,5 decoded, writeback x10=5 -> a0=5 next cycle; write x0=7 -> read x0 = 0.
- REQ-031 lw x5,0(x1) in E then add x6,x5,x2 in D -> hazard_o=1, next cycle valid_e=0; following cycle add in E with rs1_addr_e=5.
- REQ-032 stall_i=1 for 3 cycles with sub in E -> all *_e stable 3 cycles; flush_i=1 plus stall_i=1 -> valid_e=0 next cycle.
- REQ-033 reg_write_w=1, rd_w=3, result_w=0xDEAD, instr_d reads x3 -> rs1_e=0xDEAD next cycle only with DECODE_BYPASS_EN; old value without.
- REQ-034 NREG=16 build: addr field 5'b10011 aliases to x3; rd_e width 4.
